// File: rtl/led_pkg.sv
// Shared constants for the LED colour sequencer: step direction encoding
// and the default colour-code geometry.
package led_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int DEF_CH       = 2;
  localparam int DEF_WIDTH    = 3;
  localparam int DEF_MIN_VAL  = 1;
  localparam int DEF_MAX_VAL  = 6;
  localparam int DEF_AUTO_DIV = 4;

endpackage

// File: rtl/led_channel_step.sv
// One LED channel: holds its colour code and steps it up or down through
// [MIN_VAL, MAX_VAL] on request, pulsing wrap when the range rolls over.
module led_channel_step
  import led_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MIN_VAL = DEF_MIN_VAL,
  parameter int MAX_VAL = DEF_MAX_VAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             dir,
  output logic [WIDTH-1:0] colour,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MIN_C = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] colour_q, colour_d;
  logic             wrap_q, wrap_d;

  // Next colour and wrap flag for a single step in the requested direction.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    colour_d = colour_q;
    wrap_d   = 1'b0;
    if (adv) begin
      if (colour_q < MIN_C || colour_q > MAX_C) begin
        // Off (0) or any illegal code enters the range without a wrap.
        colour_d = (dir == DIR_UP) ? MIN_C : MAX_C;
      end else if (dir == DIR_UP) begin
        if (colour_q == MAX_C) begin
          colour_d = MIN_C;
          wrap_d   = 1'b1;
        end else begin
          colour_d = colour_q + WIDTH'(1);
        end
      end else begin
        if (colour_q == MIN_C) begin
          colour_d = MAX_C;
          wrap_d   = 1'b1;
        end else begin
          colour_d = colour_q - WIDTH'(1);
        end
      end
    end
  end

  // Colour and wrap registers with synchronous reset to the off state.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      colour_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      colour_q <= colour_d;
      wrap_q   <= wrap_d;
    end
  end

  assign colour = colour_q;
  assign wrap   = wrap_q;

endmodule

// File: rtl/led_colour_seq.sv
// Multi-channel LED colour sequencer: a shared prescaler produces a periodic
// auto-advance tick; each channel steps on its button or on the tick.
module led_colour_seq
  import led_pkg::*;
#(
  parameter int CH       = DEF_CH,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MIN_VAL  = DEF_MIN_VAL,
  parameter int MAX_VAL  = DEF_MAX_VAL,
  parameter int AUTO_DIV = DEF_AUTO_DIV
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       button,
  input  logic                dir,
  input  logic                auto_en,
  output logic [CH*WIDTH-1:0] colour,
  output logic [CH-1:0]       wrap
);

  localparam int               CNT_W    = $clog2(AUTO_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AUTO_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;

  // Tick on the last prescaler count; the counter parks at 0 while disabled.
  always_comb begin
    tick  = auto_en && (cnt_q == CNT_LAST);
    cnt_d = '0;
    if (auto_en && !tick) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Prescaler register, cleared by reset so progress is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Button and tick are OR-ed so a coincident pair still makes one step.
  for (genvar i = 0; i < CH; i++) begin : g_ch
    led_channel_step #(
      .WIDTH  (WIDTH),
      .MIN_VAL(MIN_VAL),
      .MAX_VAL(MAX_VAL)
    ) u_step (
      .clk   (clk),
      .rst   (rst),
      .adv   (button[i] | tick),
      .dir   (dir),
      .colour(colour[i*WIDTH +: WIDTH]),
      .wrap  (wrap[i])
    );
  end

endmodule

// File: tb/tb_led_colour_seq.sv
// Self-checking bench for led_colour_seq: default build with a scoreboard
// model, plus a wide-range build and a single-value-range build.
module tb_led_colour_seq;
  import led_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default configuration: CH=2, WIDTH=3, range 1..6, AUTO_DIV=4.
  logic [1:0]  b0 = '0;
  logic        d0 = 1'b0, a0 = 1'b0;
  logic [5:0]  col0;
  logic [1:0]  w0;
  // Wide configuration: CH=3, WIDTH=4, range 2..9.
  logic [2:0]  b1 = '0;
  logic        d1 = 1'b0, a1 = 1'b0;
  logic [11:0] col1;
  logic [2:0]  w1;
  // Degenerate range: CH=1, MIN_VAL=MAX_VAL=5, AUTO_DIV=2.
  logic [0:0]  b2 = '0;
  logic        d2 = 1'b0, a2 = 1'b0;
  logic [2:0]  col2;
  logic [0:0]  w2;

  led_colour_seq dut0 (
    .clk(clk), .rst(rst), .button(b0), .dir(d0), .auto_en(a0),
    .colour(col0), .wrap(w0)
  );

  led_colour_seq #(.CH(3), .WIDTH(4), .MIN_VAL(2), .MAX_VAL(9), .AUTO_DIV(4)) dut1 (
    .clk(clk), .rst(rst), .button(b1), .dir(d1), .auto_en(a1),
    .colour(col1), .wrap(w1)
  );

  led_colour_seq #(.CH(1), .WIDTH(3), .MIN_VAL(5), .MAX_VAL(5), .AUTO_DIV(2)) dut2 (
    .clk(clk), .rst(rst), .button(b2), .dir(d2), .auto_en(a2),
    .colour(col2), .wrap(w2)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model for dut0 ----------------
  int m_col[2] = '{0, 0};
  int m_cnt    = 0;

  function automatic int up_next(input int v, input int lo, input int hi);
    int n = hi - lo + 1;
    if (v < lo || v > hi) return lo;
    return lo + ((v - lo + 1) % n);
  endfunction

  function automatic int down_next(input int v, input int lo, input int hi);
    int n = hi - lo + 1;
    if (v < lo || v > hi) return hi;
    return lo + ((v - lo + n - 1) % n);
  endfunction

  function automatic bit is_wrap(input int v, input bit dn, input int lo, input int hi);
    return (v >= lo && v <= hi) && (dn ? (v == lo) : (v == hi));
  endfunction

  task automatic model_step(input logic r, input logic [1:0] b, input logic d, input logic a,
                            output logic [5:0] ec, output logic [1:0] ew);
    bit tk;
    ew = '0;
    if (r) begin
      m_col = '{0, 0};
      m_cnt = 0;
    end else begin
      tk    = a && (m_cnt == DEF_AUTO_DIV - 1);
      m_cnt = a ? (m_cnt + 1) % DEF_AUTO_DIV : 0;
      for (int i = 0; i < 2; i++) begin
        if (b[i] || tk) begin
          ew[i]    = is_wrap(m_col[i], d, 1, 6);
          m_col[i] = d ? down_next(m_col[i], 1, 6) : up_next(m_col[i], 1, 6);
        end
      end
    end
    ec = {3'(m_col[1]), 3'(m_col[0])};
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    string      name;
    logic [5:0] col;
    logic [1:0] wr;
  } exp_t;
  exp_t sb_q[$];

  // One dut0 cycle: drive at negedge, queue the expectation, compare after the edge.
  task automatic drive(input logic r, input logic [1:0] b, input logic d, input logic a,
                       input string name, input bit use_exp = 1'b0,
                       input logic [5:0] xc = '0, input logic [1:0] xw = '0);
    exp_t       e;
    logic [5:0] mc;
    logic [1:0] mw;
    @(negedge clk);
    rst = r; b0 = b; d0 = d; a0 = a;
    b1 = '0; a1 = 1'b0; b2 = '0; a2 = 1'b0;
    model_step(r, b, d, a, mc, mw);
    e.name = name;
    e.col  = use_exp ? xc : mc;
    e.wr   = use_exp ? xw : mw;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({e.name, "/colour"}, 32'(col0), 32'(e.col));
    check({e.name, "/wrap"}, 32'(w0), 32'(e.wr));
  endtask

  // One cycle for dut1/dut2 with dut0 idle.
  task automatic cyc_o(input logic r, input logic [2:0] b1v, input logic d1v,
                       input logic b2v, input logic d2v, input logic a2v);
    @(negedge clk);
    rst = r; b0 = '0; a0 = 1'b0;
    b1 = b1v; d1 = d1v; a1 = 1'b0;
    b2 = b2v; d2 = d2v; a2 = a2v;
    @(posedge clk);
    #1;
  endtask

  // ---------------- per-cycle legality monitor on dut0 ----------------
  logic rst_d  = 1'b1;
  bit   mon_en = 1'b0;
  bit   seen[2];
  int   prev[2];
  always @(posedge clk) rst_d <= rst;

  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        int v;
        v = int'(col0[i*3 +: 3]);
        if (rst_d) begin
          seen[i] = 1'b0;
        end else begin
          checks++;
          if (v == 7 || v > 6 || (v == 0 && seen[i])) begin
            errors++;
            $display("FAIL mon_legal ch%0d: got %0d expected 1..6 (or 0 before first step)", i, v);
          end
          if (prev[i] == 0 && v != 0) begin
            checks++;
            if (w0[i] !== 1'b0) begin
              errors++;
              $display("FAIL mon_wrap_from_off ch%0d: got wrap=%b expected 0", i, w0[i]);
            end
          end
          if (v != 0) seen[i] = 1'b1;
        end
        prev[i] = v;
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic       r;
    logic [1:0] b;
    logic       d;
    logic       a;
    logic [5:0] c;
    logic [1:0] w;
  } vec_t;
  vec_t tbl[9];

  initial begin
    int seq30[7];
    int v;

    // Reset then button[0] held 8 cycles, dir up.
    tbl[0] = '{1'b1, 2'b00, 1'b0, 1'b0, 6'd0, 2'b00};
    tbl[1] = '{1'b0, 2'b01, 1'b0, 1'b0, 6'd1, 2'b00};
    tbl[2] = '{1'b0, 2'b01, 1'b0, 1'b0, 6'd2, 2'b00};
    tbl[3] = '{1'b0, 2'b01, 1'b0, 1'b0, 6'd3, 2'b00};
    tbl[4] = '{1'b0, 2'b01, 1'b0, 1'b0, 6'd4, 2'b00};
    tbl[5] = '{1'b0, 2'b01, 1'b0, 1'b0, 6'd5, 2'b00};
    tbl[6] = '{1'b0, 2'b01, 1'b0, 1'b0, 6'd6, 2'b00};
    tbl[7] = '{1'b0, 2'b01, 1'b0, 1'b0, 6'd1, 2'b01};
    tbl[8] = '{1'b0, 2'b01, 1'b0, 1'b0, 6'd2, 2'b00};
    for (int k = 0; k < 9; k++) begin
      drive(tbl[k].r, tbl[k].b, tbl[k].d, tbl[k].a, $sformatf("up_tbl%0d", k),
            1'b1, tbl[k].c, tbl[k].w);
      if (k == 0) mon_en = 1'b1;
    end

    // dir=1 from reset, button[1]: 6,5,4,3,2,1 then 6 with wrap.
    seq30 = '{6, 5, 4, 3, 2, 1, 6};
    drive(1'b1, 2'b00, 1'b1, 1'b0, "down_rst", 1'b1, 6'd0, 2'b00);
    for (int k = 0; k < 7; k++) begin
      drive(1'b0, 2'b10, 1'b1, 1'b0, $sformatf("down%0d", k), 1'b1,
            {3'(seq30[k]), 3'b000}, (k == 6) ? 2'b10 : 2'b00);
    end

    // Direction change applies on the very next step.
    drive(1'b0, 2'b10, 1'b0, 1'b0, "dirchg_up", 1'b1, 6'o10, 2'b10);
    drive(1'b0, 2'b10, 1'b1, 1'b0, "dirchg_dn", 1'b1, 6'o60, 2'b10);

    // Auto-advance only: both channels step once every 4 cycles.
    drive(1'b1, 2'b00, 1'b0, 1'b1, "auto_rst", 1'b1, 6'd0, 2'b00);
    for (int k = 1; k <= 12; k++) begin
      v = k / 4;
      drive(1'b0, 2'b00, 1'b0, 1'b1, $sformatf("auto%0d", k), 1'b1,
            {3'(v), 3'(v)}, 2'b00);
    end

    // Button and tick on the same edge give a single step.
    drive(1'b1, 2'b00, 1'b0, 1'b1, "both_rst", 1'b1, 6'd0, 2'b00);
    drive(1'b0, 2'b01, 1'b0, 1'b1, "both1", 1'b1, 6'o01, 2'b00);
    drive(1'b0, 2'b01, 1'b0, 1'b1, "both2", 1'b1, 6'o02, 2'b00);
    drive(1'b0, 2'b01, 1'b0, 1'b1, "both3", 1'b1, 6'o03, 2'b00);
    drive(1'b0, 2'b01, 1'b0, 1'b1, "both4", 1'b1, 6'o14, 2'b00);

    // Reset mid-sequence and mid-prescale discards all progress.
    drive(1'b1, 2'b00, 1'b0, 1'b0, "mid_rst0", 1'b1, 6'd0, 2'b00);
    for (int k = 1; k <= 4; k++)
      drive(1'b0, 2'b01, 1'b0, 1'b0, $sformatf("mid_ch0_%0d", k), 1'b1, 6'(k), 2'b00);
    drive(1'b0, 2'b00, 1'b0, 1'b1, "mid_pre1", 1'b1, 6'o04, 2'b00);
    drive(1'b0, 2'b00, 1'b0, 1'b1, "mid_pre2", 1'b1, 6'o04, 2'b00);
    drive(1'b1, 2'b01, 1'b1, 1'b1, "mid_rst", 1'b1, 6'd0, 2'b00);
    for (int k = 1; k <= 3; k++)
      drive(1'b0, 2'b00, 1'b0, 1'b1, $sformatf("mid_wait%0d", k), 1'b1, 6'd0, 2'b00);
    drive(1'b0, 2'b00, 1'b0, 1'b1, "mid_tick", 1'b1, 6'o11, 2'b00);

    // Random traffic against the model, including occasional resets.
    for (int k = 0; k < 80; k++) begin
      drive(($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("rand%0d", k));
    end

    // Wide build: up 2..9,2 on channel 0.
    cyc_o(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("w_rst", 32'(col1), 32'd0);
    for (int k = 0; k < 9; k++) begin
      cyc_o(1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("w_up%0d", k), 32'(col1[3:0]), (k < 8) ? 32'(2 + k) : 32'd2);
      check($sformatf("w_upwrap%0d", k), 32'(w1), (k == 8) ? 32'd1 : 32'd0);
    end
    check("w_up_others", 32'(col1[11:4]), 32'd0);

    // Wide build: down 9..2,9 on channel 2.
    cyc_o(1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) begin
      cyc_o(1'b0, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0);
      check($sformatf("w_dn%0d", k), 32'(col1[11:8]), (k < 8) ? 32'(9 - k) : 32'd9);
      check($sformatf("w_dnwrap%0d", k), 32'(w1), (k == 8) ? 32'd4 : 32'd0);
    end
    check("w_dn_others", 32'(col1[7:0]), 32'd0);

    // Single-value range: every step from the lit value holds it and wraps.
    cyc_o(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc_o(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    check("s_enter", {28'd0, col2, w2}, {28'd0, 3'd5, 1'b0});
    cyc_o(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    check("s_up", {28'd0, col2, w2}, {28'd0, 3'd5, 1'b1});
    cyc_o(1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0);
    check("s_dn", {28'd0, col2, w2}, {28'd0, 3'd5, 1'b1});
    cyc_o(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("s_hold", {28'd0, col2, w2}, {28'd0, 3'd5, 1'b0});

    // Single-value range with AUTO_DIV=2: tick every second cycle.
    cyc_o(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc_o(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    check("s_auto1", {28'd0, col2, w2}, {28'd0, 3'd0, 1'b0});
    cyc_o(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    check("s_auto2", {28'd0, col2, w2}, {28'd0, 3'd5, 1'b0});
    cyc_o(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    check("s_auto3", {28'd0, col2, w2}, {28'd0, 3'd5, 1'b0});
    cyc_o(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    check("s_auto4", {28'd0, col2, w2}, {28'd0, 3'd5, 1'b1});

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
